// File: rtl/pulse_hs_pkg.sv
// Shared types and defaults for the pulse handshake transmitter.
package pulse_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  localparam int CNT_W_DEF    = 4;
  localparam int SYNC_STG_DEF = 2;

endpackage

// File: rtl/pulse_hs_tx_if.sv
// Source-side pulse handshake bus: event/ack/clear inputs toward the
// transmitter, request and status outputs back to the source domain.
interface pulse_hs_tx_if
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             in_pulse;
  logic             ack_async;
  logic             ovf_clr;
  logic             req;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;
  logic             tmo;

  modport master (
    output in_pulse, ack_async, ovf_clr,
    input  req, busy, done, pend_cnt, ovf, tmo
  );

  modport slave (
    input  in_pulse, ack_async, ovf_clr,
    output req, busy, done, pend_cnt, ovf, tmo
  );
endinterface

// File: rtl/sync_bit.sv
// N-flop single-bit synchronizer, async active-high reset to 0.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] sync_q, sync_d;

  // shift the async input in at the low end
  always_comb sync_d = {sync_q[N-2:0], d};

  // synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[N-1];
endmodule

// File: rtl/pulse_hs_tx.sv
// Pulse handshake transmitter: counts source pulses and issues them one at
// a time as a 4-phase req/ack handshake. Optional REQ watchdog is built
// when PULSE_TX_TIMEOUT_EN is defined; otherwise tmo is tied low.
module pulse_hs_tx
  import pulse_hs_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STG    = SYNC_STG_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  pulse_hs_tx_if.slave  bus
);
  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_s;
  logic             launch;
  logic             drop;

  sync_bit #(.N(SYNC_STG)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack_async),
    .q   (ack_s)
  );

  // handshake FSM: launch from IDLE when work is queued, then wait ack high/low
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          state_d = REQ;
          req_d   = 1'b1;
          launch  = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d = WAIT_LOW;
          req_d   = 1'b0;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pending counter: a pulse and a launch in one cycle cancel; saturate, never wrap
  always_comb begin
    cnt_d = cnt_q;
    drop  = 1'b0;
    if (bus.in_pulse && !launch) begin
      if (cnt_q == '1) drop  = 1'b1;
      else             cnt_d = cnt_q + CNT_W'(1);
    end else if (!bus.in_pulse && launch) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // sticky overflow; a drop in the clearing cycle keeps the flag set
  always_comb ovf_d = drop | (ovf_q & ~bus.ovf_clr);

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.req      = req_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.pend_cnt = cnt_q;
  assign bus.ovf      = ovf_q;

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wd_q, wd_d;
  logic          tmo_q, tmo_d;

  // watchdog: restart on launch, count REQ cycles, flag once limit is reached
  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_q;
    if (launch) begin
      wd_d = '0;
    end else if (state_q == REQ) begin
      if (wd_q != TW'(TIMEOUT_CYC))     wd_d  = wd_q + TW'(1);
      if (wd_q == TW'(TIMEOUT_CYC - 1)) tmo_d = 1'b1;
    end
  end

  // watchdog registers; tmo clears only on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.tmo = tmo_q;
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign bus.tmo = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_hs_tx.sv
// Directed bench for pulse_hs_tx: instance A (CNT_W=4, TIMEOUT_CYC=20) and
// instance B (CNT_W=2) for overflow. Auto-responder acks 3 cycles after req.
module tb_pulse_hs_tx;
  import pulse_hs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_hs_tx_if #(.CNT_W(4)) a_if ();
  pulse_hs_tx_if #(.CNT_W(2)) b_if ();

  pulse_hs_tx #(.CNT_W(4), .SYNC_STG(2), .TIMEOUT_CYC(20)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );
  pulse_hs_tx #(.CNT_W(2), .SYNC_STG(2), .TIMEOUT_CYC(20)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int TMO_EXP = 1;
`else
  localparam int TMO_EXP = 0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // receiver models: follow req with ack after 3 samples unless held
  logic a_hold = 1'b0;
  logic b_hold = 1'b0;

  initial begin
    int rc;
    rc = 0;
    a_if.ack_async = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        a_if.ack_async = 1'b0;
        rc = 0;
      end else if (!a_hold && (a_if.req != a_if.ack_async)) begin
        rc++;
        if (rc == 3) begin
          a_if.ack_async = a_if.req;
          rc = 0;
        end
      end else begin
        rc = 0;
      end
    end
  end

  initial begin
    int rc;
    rc = 0;
    b_if.ack_async = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        b_if.ack_async = 1'b0;
        rc = 0;
      end else if (!b_hold && (b_if.req != b_if.ack_async)) begin
        rc++;
        if (rc == 3) begin
          b_if.ack_async = b_if.req;
          rc = 0;
        end
      end else begin
        rc = 0;
      end
    end
  end

  // negedge monitor: done counts, gap tracking, latency timestamps
  int cyc = 0, a_done_n = 0, b_done_n = 0, a_gap1 = 0, idle_run = 100;
  int t_ack_r = 0, t_req_f = 0, t_ack_f = 0, t_done = 0;

  initial begin
    logic p_busy, p_req, p_ack;
    p_busy = 1'b0; p_req = 1'b0; p_ack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_if.done) begin a_done_n++; t_done = cyc; end
      if (b_if.done) b_done_n++;
      if (a_if.ack_async && !p_ack) t_ack_r = cyc;
      if (!a_if.ack_async && p_ack) t_ack_f = cyc;
      if (!a_if.req && p_req) t_req_f = cyc;
      if (a_if.busy && !p_busy && idle_run == 1) a_gap1++;
      idle_run = a_if.busy ? 0 : idle_run + 1;
      p_busy = a_if.busy; p_req = a_if.req; p_ack = a_if.ack_async;
    end
  end

  task automatic wait_done(input bit on_b, input int target, input string tag);
    int n;
    n = 0;
    while ((on_b ? b_done_n : a_done_n) < target && n < 300) begin
      tick();
      n++;
    end
    repeat (8) tick();
    chk(tag, on_b ? b_done_n : a_done_n, target);
  endtask

  initial begin
    int d0, g0;
    a_if.in_pulse = 1'b0; a_if.ovf_clr = 1'b0;
    b_if.in_pulse = 1'b0; b_if.ovf_clr = 1'b0;

    // reset state
    rst = 1'b1;
    #1;
    chk("rst_req",  a_if.req, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_pend", a_if.pend_cnt, 0);
    chk("rst_ovf",  a_if.ovf, 0);
    chk("rst_tmo",  a_if.tmo, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single event
    d0 = a_done_n;
    a_if.in_pulse = 1'b1; tick(); a_if.in_pulse = 1'b0;
    chk("single_pend1", a_if.pend_cnt, 1);
    chk("single_req0",  a_if.req, 0);
    tick();
    chk("single_req1",  a_if.req, 1);
    chk("single_pend0", a_if.pend_cnt, 0);
    chk("single_busy1", a_if.busy, 1);
    wait_done(1'b0, d0 + 1, "single_done");
    chk("single_pend_end", a_if.pend_cnt, 0);
    chk("single_busy_end", a_if.busy, 0);
    chk("single_req_end",  a_if.req, 0);
    chk("ack_to_req_fall", t_req_f - t_ack_r, 3);
    chk("ack_to_done",     t_done - t_ack_f, 3);

    // burst of 5
    d0 = a_done_n; g0 = a_gap1;
    a_if.in_pulse = 1'b1; repeat (5) tick(); a_if.in_pulse = 1'b0;
    chk("burst_peak", a_if.pend_cnt, 4);
    chk("burst_req",  a_if.req, 1);
    wait_done(1'b0, d0 + 5, "burst_done");
    chk("burst_gaps", a_gap1 - g0, 4);
    chk("burst_pend_end", a_if.pend_cnt, 0);

    // pulse on the launch cycle
    d0 = a_done_n;
    a_if.in_pulse = 1'b1; tick();
    chk("sim_pend_pre", a_if.pend_cnt, 1);
    tick(); a_if.in_pulse = 1'b0;
    chk("sim_pend", a_if.pend_cnt, 1);
    chk("sim_req",  a_if.req, 1);
    wait_done(1'b0, d0 + 2, "sim_done");

    // reset mid-REQ
    a_hold = 1'b1; d0 = a_done_n;
    a_if.in_pulse = 1'b1; repeat (3) tick(); a_if.in_pulse = 1'b0;
    chk("mid_pend2", a_if.pend_cnt, 2);
    chk("mid_req1",  a_if.req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req",  a_if.req, 0);
    chk("mid_rst_busy", a_if.busy, 0);
    chk("mid_rst_done", a_if.done, 0);
    chk("mid_rst_pend", a_if.pend_cnt, 0);
    chk("mid_rst_ovf",  a_if.ovf, 0);
    repeat (2) tick();
    rst = 1'b0; a_hold = 1'b0;
    repeat (10) tick();
    chk("mid_no_done", a_done_n, d0);
    a_if.in_pulse = 1'b1; tick(); a_if.in_pulse = 1'b0;
    wait_done(1'b0, d0 + 1, "mid_after_done");

    // overflow on the 2-bit instance
    b_hold = 1'b1; d0 = b_done_n;
    b_if.in_pulse = 1'b1; repeat (6) tick(); b_if.in_pulse = 1'b0;
    chk("ovf_pend_sat", b_if.pend_cnt, 3);
    chk("ovf_set",      b_if.ovf, 1);
    chk("ovf_req",      b_if.req, 1);
    b_hold = 1'b0;
    wait_done(1'b1, d0 + 4, "ovf_done4");
    chk("ovf_sticky", b_if.ovf, 1);
    b_if.ovf_clr = 1'b1; tick(); b_if.ovf_clr = 1'b0;
    chk("ovf_cleared", b_if.ovf, 0);

    // drop in the same cycle as clear keeps ovf set
    b_hold = 1'b1; d0 = b_done_n;
    b_if.in_pulse = 1'b1; repeat (4) tick();
    chk("drop_pre_pend", b_if.pend_cnt, 3);
    chk("drop_pre_ovf",  b_if.ovf, 0);
    b_if.ovf_clr = 1'b1; tick();
    b_if.in_pulse = 1'b0; b_if.ovf_clr = 1'b0;
    chk("drop_wins", b_if.ovf, 1);
    chk("drop_pend", b_if.pend_cnt, 3);
    b_hold = 1'b0;
    wait_done(1'b1, d0 + 4, "drop_done4");

    // watchdog
    a_hold = 1'b1; d0 = a_done_n;
    a_if.in_pulse = 1'b1; tick(); a_if.in_pulse = 1'b0;
    tick();
    chk("tmo_req_launch", a_if.req, 1);
    repeat (19) tick();
    chk("tmo_before", a_if.tmo, 0);
    tick();
    chk("tmo_at_limit", a_if.tmo, TMO_EXP);
    chk("tmo_req_held", a_if.req, 1);
    a_hold = 1'b0;
    wait_done(1'b0, d0 + 1, "tmo_late_done");
    chk("tmo_sticky", a_if.tmo, TMO_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_hs_tx.md
# pulse_hs_tx

Source-side transmitter for a 4-phase req/ack pulse crossing. Single-cycle pulses in the `clk` domain are counted, then issued one at a time as a level `req` toward a destination-domain receiver; the receiver's `ack_async` is synchronized internally. It pairs with the destination-side pulse synchronizer so bursts of source pulses are never lost, only queued or flagged.

## Interface
- `CNT_W`, default 4: width of the pending-pulse counter; at most 2^CNT_W−1 pulses are queued.
- `SYNC_STG`, default 2: synchronizer depth for `ack_async`; must be ≥2.
- `TIMEOUT_CYC`, default 255: REQ-state watchdog limit. Used only with `PULSE_TX_TIMEOUT_EN`.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset. **Asynchronous, active-high.**
- `in_pulse` input, 1 bit: single-cycle source event.
- `ack_async` input, 1 bit: acknowledge from the destination domain, not synchronized.
- `ovf_clr` input, 1 bit: clears `ovf`.
- `req` output, 1 bit: registered handshake request.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `done` output, 1 bit: one-cycle pulse when a handshake completes.
- `pend_cnt` output, CNT_W bits: number of queued, unissued pulses.
- `ovf` output, 1 bit: sticky flag set when a pulse is dropped because the counter is full.
- `tmo` output, 1 bit: sticky watchdog flag. Tied 0 without `PULSE_TX_TIMEOUT_EN`.

## Operation
- `ack_s` is `ack_async` passed through SYNC_STG flops. The FSM uses only `ack_s`.
- FSM states and transitions:
  - IDLE → REQ when `pend_cnt`≠0. On that edge: `req`←1 and `pend_cnt` decrements.
  - REQ → WAIT_LOW when `ack_s`=1. On that edge: `req`←0.
  - WAIT_LOW → IDLE when `ack_s`=0. On that edge: `done`←1 for exactly one cycle.
- Pending counter rules:
  - `in_pulse` alone: +1.
  - Launch alone: −1.
  - `in_pulse` and launch in the same cycle: unchanged.
  - `in_pulse` at full count (2^CNT_W−1) with no launch that cycle: counter holds, pulse is dropped, `ovf`←1.
  - Counter never wraps.
- `ovf` clearing:
  - `ovf_clr` clears `ovf`.
  - A drop in the same cycle as `ovf_clr` wins: `ovf` remains 1.
- `in_pulse` held high for k cycles counts as k events.
- Spurious `ack_s`=1 while in IDLE is ignored. The FSM never leaves REQ except on `ack_s`.

## Timing
- Reset values: `req`=0, `busy`=0, `done`=0, `pend_cnt`=0, `ovf`=0, `tmo`=0; state=IDLE; synchronizer flops=0.
- Asserting `rst` mid-handshake forces all of the above immediately. Queued pulses are discarded, and the receiver must also be reset.
- Event to request, from idle with `pend_cnt`=0:
  - `in_pulse` sampled at edge n → `pend_cnt`=1 after n.
  - `req`=1 and `pend_cnt`=0 after edge n+1.
- Ack rise at the pin → `req` falls SYNC_STG+1 edges later.
- Ack fall at the pin → `done` is high SYNC_STG+1 edges later.
- Back-to-back issue: after WAIT_LOW→IDLE, `req` reasserts on the next edge if `pend_cnt`≠0. There is exactly one IDLE cycle between handshakes.
- `busy` is registered state decode: it goes high the same cycle `req` rises and goes low the same cycle `done` pulses.

## Configuration
- Macro: `PULSE_TX_TIMEOUT_EN`.
- Defined:
  - A counter runs while in REQ and clears on entering REQ.
  - When it reaches TIMEOUT_CYC, `tmo`←1 (sticky; cleared only by `rst`).
  - The FSM keeps waiting; `req` stays high.
- Undefined:
  - No counter logic is built.
  - `tmo` is constant 0.

## Structure
- Package `pulse_hs_pkg` holds:
  - the state enum (IDLE, REQ, WAIT_LOW) as a 2-bit typedef;
  - localparam defaults for CNT_W and SYNC_STG.
- Sub-module `sync_bit`: a parameterized N-flop single-bit synchronizer with async active-high reset. It is instantiated once for `ack_async` and is reusable by the receiver.
- The counter, FSM and watchdog are in the top module.

## Test plan
- Single event: reset, then one `in_pulse`; receiver model acks 3 clk after `req` rises and drops ack 3 clk after `req` falls → `req` high 2 edges after the pulse; exactly one `done`; `pend_cnt` returns to 0; `busy` ends at 0.
- Burst: 5 consecutive `in_pulse` cycles → `pend_cnt` peaks at 4 (one already launched); 5 handshakes; 5 `done` pulses; each pair of requests separated by one IDLE cycle.
- Overflow with CNT_W=2 and ack withheld:
  - 6 pulses → `pend_cnt` saturates at 3 and `ovf`=1.
  - Release ack → exactly 4 `done` pulses.
  - `ovf_clr` → `ovf`=0.
- Simultaneous events: `in_pulse` on the exact launch cycle with `pend_cnt`=1 → `pend_cnt` stays 1 and `req` rises.
- Reset mid-REQ with `pend_cnt`=2 → all outputs 0 immediately; no `done`; a later single pulse completes normally.
- With `PULSE_TX_TIMEOUT_EN` and TIMEOUT_CYC=20, ack withheld → `tmo`=1 after 20 REQ cycles while `req` stays 1; a late ack then completes with `done`=1. Without the macro → `tmo` stays 0.
